// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM state encoding, the canonical NOP and the
// sequential PC step.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

    // The branch strobe is active-high despite its name.
    function automatic logic is_redirect(input logic branch_taken, input logic jump_taken);
        return branch_taken || jump_taken;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response plus the bundle handed
// to decode.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/next_pc_sel.sv
// Next-PC mux: jump beats branch beats sequential increment beats hold.
// Redirect targets are forced to word alignment.
module next_pc_sel
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branchN,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            inc,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    always_comb begin
        redirect = is_redirect(branchN, jump);
        if (jump) begin
            next_pc = jump_target & ALIGN_MASK;
        end else if (branchN) begin
            next_pc = branch_target & ALIGN_MASK;
        end else if (inc) begin
            next_pc = pc + XLEN'(PC_INC);
        end else begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch unit: issues one imem request at a time,
// holds the returned instruction for decode and handles branch/jump redirects.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            branchN,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            stall,
    pc_fetch_unit_if.master bus
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            discard;
    logic            req_en;
    logic            redirect;
    logic            granted;
    logic            resp;
    logic            accept;
    logic            capture;

    assign granted = (state == S_REQ) && req_en && bus.imem_gnt;
    assign resp    = (state == S_WAIT) && bus.imem_rvalid;
    assign accept  = (state == S_HOLD) && bus.instr_ready && !stall;
    // A redirect arriving together with the response also kills that response.
    assign capture = resp && !discard && !redirect;

    next_pc_sel #(
        .XLEN(XLEN)
    ) u_next_pc_sel (
        .pc           (pc),
        .branchN      (branchN),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .inc          (accept),
        .next_pc      (pc_nxt),
        .redirect     (redirect)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (granted) state_nxt = S_WAIT;
            S_WAIT:  if (resp) state_nxt = capture ? S_HOLD : S_REQ;
            S_HOLD:  if (redirect || accept) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    // req_en keeps imem_req low through the reset cycle without a fourth state.
    always_comb begin
        bus.imem_req    = (state == S_REQ) && req_en;
        bus.instr_valid = (state == S_HOLD);
    end

    assign bus.imem_addr = pc;
    assign bus.instr     = instr_q;
    assign bus.instr_pc  = instr_pc_q;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            pc         <= RESET_PC;
            discard    <= 1'b0;
            req_en     <= 1'b0;
            instr_q    <= XLEN'(NOP_INSTR);
            instr_pc_q <= RESET_PC;
        end else begin
            req_en <= 1'b1;
            pc     <= pc_nxt;
            // pc only moves during an outstanding request on a redirect, so on
            // an undiscarded response it still names the requested address.
            if (resp) begin
                discard <= 1'b0;
            end else if (redirect && (granted || state == S_WAIT)) begin
                discard <= 1'b1;
            end
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed reset/fetch/stall/wrap sequences, a table of
// redirect cases and a randomized run against a transaction-level PC model.
module tb_pc_fetch_unit;

    localparam int ST_REQ  = 0;
    localparam int ST_WAIT = 1;
    localparam int ST_HOLD = 2;

    typedef struct {
        int          st;
        bit          j;
        bit          b;
        logic [31:0] jt;
        logic [31:0] bt;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        branchN;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit_if #(.XLEN(32)) bus ();
    pc_fetch_unit_if #(.XLEN(32)) bus2 ();

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstN(rstN), .branchN(branchN), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .stall(stall), .bus(bus)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rstN(rstN), .branchN(branchN), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .stall(stall), .bus(bus2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h0001_0001) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        branchN = 0; jump = 0; stall = 0;
        branch_target = 0; jump_target = 0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.instr_ready = 0;
        bus2.imem_gnt = 0; bus2.imem_rvalid = 0; bus2.imem_rdata = 0; bus2.instr_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstN = 0;
        tick();
        tick();
        rstN = 1;
        tick();
    endtask

    // Simple memory: grant at once, respond the cycle after grant; stop in S_HOLD.
    task automatic run_to_hold(input string tag);
        bit          ok;
        bit          outst;
        logic [31:0] ga;
        ok = 0; outst = 0; ga = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.instr_valid) begin
                ok = 1;
            end else begin
                bus.imem_rvalid = outst;
                bus.imem_rdata  = outst ? mem(ga) : 32'h0;
                bus.imem_gnt    = bus.imem_req && !outst;
                if (outst) begin
                    outst = 0;
                end else if (bus.imem_req) begin
                    outst = 1;
                    ga = bus.imem_addr;
                end
                tick();
            end
        end
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: instr_valid stayed 0 for 20 cycles, want 1", tag);
        end
    endtask

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] gaddr;
        logic [31:0] tgt;
        logic [31:0] hold_pc;
        bit          outst, exp_inv, redir, rdy, stl, g, rv;
        int          lat, kind;

        vecs[0] = '{ST_WAIT, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0102, 32'h0000_0100};
        vecs[1] = '{ST_REQ,  1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300, 32'h0000_0200};
        vecs[2] = '{ST_HOLD, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0403, 32'h0000_0400};
        vecs[3] = '{ST_WAIT, 1'b1, 1'b0, 32'h0000_07FF, 32'h0000_0000, 32'h0000_07FC};
        vecs[4] = '{ST_HOLD, 1'b1, 1'b1, 32'h0000_0800, 32'h0000_0900, 32'h0000_0800};
        vecs[5] = '{ST_REQ,  1'b0, 1'b1, 32'h0000_0000, 32'h0000_1001, 32'h0000_1000};

        // Reset: two low cycles, then the first request at address 0.
        idle_inputs();
        rstN = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
            chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        end
        chk("rst_instr_nop", bus.instr, 32'h0000_0013);
        chk("rst_instr_pc", bus.instr_pc, 32'h0000_0000);
        rstN = 1;
        tick();
        chk("rst_release_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rst_release_addr", bus.imem_addr, 32'h0000_0000);

        // Sequential fetch of 0x0, 0x4, 0x8.
        for (int k = 0; k < 3; k++) begin
            run_to_hold("seq");
            chk("seq_instr_pc", bus.instr_pc, 32'(k * 4));
            chk("seq_instr", bus.instr, mem(32'(k * 4)));
            bus.instr_ready = 1;
            tick();
            bus.instr_ready = 0;
        end

        // Stall in S_HOLD for 3 cycles, then resume at pc+4.
        run_to_hold("stall");
        hold_pc = 32'h0000_000C;
        chk("stall_entry_pc", bus.instr_pc, hold_pc);
        stall = 1;
        bus.instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("stall_instr_pc", bus.instr_pc, hold_pc);
            chk("stall_instr", bus.instr, mem(hold_pc));
            chk("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
        end
        stall = 0;
        tick();
        bus.instr_ready = 0;
        chk("stall_resume_req", {31'b0, bus.imem_req}, 32'd1);
        chk("stall_resume_addr", bus.imem_addr, hold_pc + 32'd4);

        // Reset in the middle of a transaction; the late response is ignored.
        do_reset();
        bus.imem_gnt = 1;
        tick();
        bus.imem_gnt = 0;
        rstN = 0;
        tick();
        rstN = 1;
        bus.imem_rvalid = 1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 0;
        chk("midrst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("midrst_req", {31'b0, bus.imem_req}, 32'd1);
        chk("midrst_addr", bus.imem_addr, 32'h0000_0000);

        // Redirect table: bring the DUT to a state, redirect, check the new fetch.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            if (vecs[v].st == ST_WAIT) begin
                bus.imem_gnt = 1;
                tick();
                bus.imem_gnt = 0;
            end else if (vecs[v].st == ST_HOLD) begin
                run_to_hold("vec_setup");
            end
            jump = vecs[v].j; branchN = vecs[v].b;
            jump_target = vecs[v].jt; branch_target = vecs[v].bt;
            tick();
            jump = 0; branchN = 0;
            if (vecs[v].st == ST_WAIT) begin
                bus.imem_rvalid = 1;
                bus.imem_rdata = 32'hBAD0_BAD0;
                tick();
                bus.imem_rvalid = 0;
            end
            chk("vec_valid_drop", {31'b0, bus.instr_valid}, 32'd0);
            chk("vec_req", {31'b0, bus.imem_req}, 32'd1);
            chk("vec_addr", bus.imem_addr, vecs[v].exp);
            if (vecs[v].st != ST_REQ) begin
                run_to_hold("vec_refetch");
                chk("vec_instr_pc", bus.instr_pc, vecs[v].exp);
                chk("vec_instr", bus.instr, mem(vecs[v].exp));
            end
        end

        // Wrap-around from 0xFFFF_FFFC.
        do_reset();
        chk("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_gnt = 1;
        tick();
        bus2.imem_gnt = 0;
        bus2.imem_rvalid = 1;
        bus2.imem_rdata = mem(32'hFFFF_FFFC);
        tick();
        bus2.imem_rvalid = 0;
        chk("wrap_valid", {31'b0, bus2.instr_valid}, 32'd1);
        chk("wrap_instr_pc", bus2.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", bus2.instr, mem(32'hFFFF_FFFC));
        bus2.instr_ready = 1;
        tick();
        bus2.instr_ready = 0;
        chk("wrap_req", {31'b0, bus2.imem_req}, 32'd1);
        chk("wrap_addr", bus2.imem_addr, 32'h0000_0000);

        // Randomized run against a transaction-level model of the PC.
        do_reset();
        exp_pc = 0; gaddr = 0; outst = 0; exp_inv = 0; lat = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (bus.imem_req) chk("rnd_imem_addr", bus.imem_addr, exp_pc);
            if (outst) chk("rnd_single_outstanding", {31'b0, bus.imem_req}, 32'd0);
            if (exp_inv) chk("rnd_valid_drop", {31'b0, bus.instr_valid}, 32'd0);
            if (bus.instr_valid) begin
                chk("rnd_instr_pc", bus.instr_pc, exp_pc);
                chk("rnd_instr", bus.instr, mem(exp_pc));
            end

            redir = ($urandom_range(0, 9) == 0);
            kind = int'($urandom_range(0, 2));
            jump = redir && (kind != 1);
            branchN = redir && (kind != 0);
            jump_target = $urandom & 32'h0000_3FFF;
            branch_target = $urandom & 32'h0000_3FFF;
            tgt = jump ? jump_target : branch_target;
            rdy = ($urandom_range(0, 1) == 1);
            stl = ($urandom_range(0, 3) == 0);
            bus.instr_ready = rdy;
            stall = stl;
            g = bus.imem_req && ($urandom_range(0, 1) == 1);
            bus.imem_gnt = g;
            rv = 0;
            if (outst) begin
                if (lat == 0) begin
                    rv = 1;
                    bus.imem_rdata = mem(gaddr);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                rv = 1;
                bus.imem_rdata = $urandom;
            end
            bus.imem_rvalid = rv;

            exp_inv = bus.instr_valid && ((rdy && !stl) || redir);
            if (outst && rv) outst = 0;
            if (g) begin
                outst = 1;
                lat = int'($urandom_range(0, 2));
                gaddr = bus.imem_addr;
            end
            if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
            else if (bus.instr_valid && rdy && !stl) exp_pc = exp_pc + 32'd4;
            tick();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter XLEN, default 32, meaning the width of the PC and instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstN, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port branchN, input, 1, branch-taken from the branch comparator.
REQ-006 SHALL have port branch_target, input, XLEN, branch destination.
REQ-007 SHALL have port jump, input, 1, JAL/JALR taken.
REQ-008 SHALL have port jump_target, input, XLEN, jump destination.
REQ-009 SHALL have port stall, input, 1, hazard hold from the decode/hazard unit.
REQ-010 SHALL have ports imem_req, output, 1 and imem_addr, output, XLEN, the instruction-memory request and its address.
REQ-011 SHALL have port imem_gnt, input, 1, request accepted this cycle.
REQ-012 SHALL have ports imem_rvalid, input, 1 and imem_rdata, input, XLEN, the response strobe and its data.
REQ-013 SHALL have ports instr_valid, output, 1; instr, output, XLEN; instr_pc, output, XLEN; these form the fetched-instruction bundle to decode.
REQ-014 SHALL have port instr_ready, input, 1, decode accepts the bundle.

Function
REQ-015 SHALL keep at most one imem request outstanding.
REQ-016 SHALL implement the FSM states S_REQ (imem_req=1), S_WAIT (awaiting imem_rvalid) and S_HOLD (instr_valid=1, awaiting instr_ready).
REQ-017 SHALL transition S_REQ->S_WAIT on imem_gnt, S_WAIT->S_HOLD on imem_rvalid, and S_HOLD->S_REQ on instr_ready && !stall.
REQ-018 SHALL capture imem_rdata and the request PC into instr/instr_pc on imem_rvalid; latency from grant to instr_valid is response latency + 1 cycle.
REQ-019 SHALL increment pc by 4 when a bundle is accepted (instr_valid && instr_ready && !stall); the increment wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
REQ-020 SHALL treat a redirect as branchN || jump; on a redirect, pc <= target with target[1:0] forced to 2'b00, jump_target taking priority when both are asserted.
REQ-021 SHALL, on a redirect in S_HOLD, deassert instr_valid the next cycle and move to S_REQ at the new PC.
REQ-022 SHALL, on a redirect in S_WAIT, set a discard flag, drop the next imem_rvalid, clear the flag, then enter S_REQ at the target.
REQ-023 SHALL, on a redirect in S_REQ without grant, replace imem_addr next cycle; with grant in the same cycle, handle it as REQ-022.
REQ-024 SHALL give a redirect priority over stall; stall SHALL freeze pc and hold instr_valid/instr/instr_pc stable.
REQ-025 SHALL keep imem_addr stable while imem_req=1 and !imem_gnt, except on a redirect.
REQ-026 SHALL ignore imem_rvalid outside S_WAIT.

Reset
REQ-027 SHALL, while rstN=0 at a clock edge, set pc=RESET_PC, state=S_REQ, discard flag=0, instr_valid=0, instr=32'h0000_0013 (NOP), and instr_pc=RESET_PC.
REQ-028 SHALL keep imem_req=0 during the reset cycle and assert it the first cycle after rstN rises.
REQ-029 SHALL let reset asserted mid-transaction abandon the outstanding request; no late response is forwarded.

Structure
REQ-030 SHALL place the FSM state typedef, the NOP constant and the PC increment constant (4) in the shared package riscv_pkg.
REQ-031 SHALL use one combinational sub-module, next_pc_sel, for the redirect/increment/hold mux and alignment masking.
REQ-032 SHALL implement all sequential logic in always_ff blocks with synchronous rstN.

Verification
REQ-033 SHALL verify reset: rstN=0 for 2 cycles -> imem_req=0, instr_valid=0; rstN=1 -> imem_req=1, imem_addr=32'h0 next cycle.
REQ-034 SHALL verify sequential fetch: gnt and rvalid one cycle apart, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8; instr equals the memory model data.
REQ-035 SHALL verify a branch in S_WAIT: branchN=1, branch_target=32'h0000_0102 -> stale rdata dropped, next imem_addr=32'h0000_0100.
REQ-036 SHALL verify a simultaneous jump and branch: jump_target=0x200, branch_target=0x300 -> next imem_addr=0x200.
REQ-037 SHALL verify stall: stall=1 for 3 cycles in S_HOLD -> instr/instr_pc unchanged, no new imem_req; resumes at pc+4.
REQ-038 SHALL verify wrap-around: RESET_PC=32'hFFFF_FFFC, one accept -> next imem_addr=32'h0000_0000.
